rsc_encoder: RTL and testbench
==============================

# rsc_encoder

Rate-1/3-constituent LTE RSC encoder (g0 = 1+D²+D³ feedback, g1 = 1+D+D³) with trellis termination, producing the interleaved systematic/parity word stream consumed by the SISO decoder `in`/`valid_in` port. It sits on the stimulus/transmit side of the decoder datapath and lets benches and loopback builds generate decoder input on-chip instead of from files. Output words are 16-bit signed soft values (BPSK-mapped) or hard bits, selected at compile time.

## Interface
- AMPL, 64, signed soft magnitude driven for each coded bit (bit 0 → +AMPL, bit 1 → −AMPL)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in  in  1  information bit
- valid_in  in  1  `in` valid; accepted on a cycle with `valid_in && ready_in`
- ready_in  out  1  encoder can accept a bit this cycle
- blklen  in  13  block length K in bits (1..6144); sampled on the first accepted bit of a block
- out  out  16  coded word: systematic, then parity, per trellis step
- valid_out  out  1  `out` valid (no backpressure; sink must take every word)
- tail_out  out  1  current word belongs to the termination section
- last_out  out  1  final word of the block (with valid_out)
- busy  out  1  block in progress (DATA or TAIL state)

## Operation
- States: IDLE, DATA, TAIL. Encoder state s = {s1,s2,s3}, cleared in IDLE.
- Per trellis step with input u: f = u^s2^s3; p = f^s1^s3; s ← {f,s1,s2}.
- IDLE: ready_in=1. Accepted bit: latch blklen (0 treated as 1) into K, count=1, encode, go DATA (or TAIL directly if K=1).
- DATA: each accepted bit encoded; on the K-th bit go TAIL.
- TAIL: 3 steps with u = s2^s3 (forces f=0); no input accepted; s = 000 afterwards; return to IDLE.
- Each step emits two words: systematic u, then parity p. Block total = 2K+6 words.
- Phase flag: ready_in = (state≠TAIL) && phase==0. Accepting a bit sets phase=1; the parity cycle clears it. Max input rate one bit per 2 cycles.
- Tail steps run back-to-back without gaps: 6 consecutive valid_out cycles.
- valid_in while ready_in=0 is ignored (bit not consumed; source holds it).
- blklen changes mid-block have no effect.

## Timing
- All outputs registered. Reset values: out=0, valid_out=0, tail_out=0, last_out=0, busy=0, ready_in=1 (first cycle after rst low).
- Bit accepted at edge n: systematic word valid in cycle n+1, parity word in n+2; ready_in low in cycle n+1, high in n+2.
- K-th bit accepted at edge n: its words at n+1, n+2; tail words at n+3..n+8; last_out in cycle n+8; ready_in returns high at n+9.
- busy high from cycle after first acceptance through the last_out cycle.
- rst asserted mid-block: next cycle all outputs at reset values, s=000, block discarded, no tail emitted.

## Configuration
- SOFT_OUT_EN defined: out = +AMPL for bit 0, −AMPL for bit 1 (two's complement, 16 bits).
- SOFT_OUT_EN undefined: out = {15'b0, bit}; AMPL unused. Sequencing and timing identical.

## Test plan
- All-zero input, blklen=4, valid_in held high, SOFT_OUT_EN defined → 14 words all +64, ready_in toggling 1/0, tail_out on words 9–14, last_out on word 14.
- Impulse: blklen=8, bits 1,0,0,0,0,0,0,0 → parity words −64,−64,−64,−64,+64 for steps 1–5; full 22-word stream matches a bit-accurate C/Python model; tail drives state to 000.
- Gapped source: valid_in asserted every 3rd cycle, random 40-bit block → stream matches model, no words emitted during gaps, two back-to-back blocks both correct (state cleared between).
- blklen=0 → treated as K=1: 8 words total, last_out on 8th.
- rst pulsed in DATA after 5 of 40 bits → valid_out low next cycle, busy=0, ready_in=1; following block of 40 random bits matches model.
- SOFT_OUT_EN undefined, impulse block → out values 0/1 only, same sequence and timing as soft run.

Source files
------------

// File: rtl/rsc_encoder.sv
// rtl/rsc_encoder.sv - LTE RSC constituent encoder with trellis termination (soft output option: SOFT_OUT_EN)
module rsc_encoder #(
  parameter int AMPL = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic [12:0] blklen,
  output logic [15:0] out,
  output logic        valid_out,
  output logic        tail_out,
  output logic        last_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic        phase;      // 1 while the parity word of the current step is pending
  logic [2:0]  s;          // {s1, s2, s3}
  logic [12:0] k_len;
  logic [12:0] count;
  logic [1:0]  tcnt;       // tail steps already started
  logic        p_q;        // parity of the step whose systematic word was just sent

  logic        accept;
  logic        tail_step;
  logic        do_step;
  logic        step_u;
  logic        step_f;
  logic        step_p;
  logic [12:0] blk_k;

  // Map a coded bit to the output word format
  function automatic logic [15:0] map_bit(input logic b);
`ifdef SOFT_OUT_EN
    return b ? 16'(-AMPL) : 16'(AMPL);
`else
    return {15'b0, b};
`endif
  endfunction

`ifndef SOFT_OUT_EN
  logic unused_ampl;
  assign unused_ampl = ^AMPL;
`endif

  assign ready_in  = (state != TAIL) && !phase;
  assign busy      = (state != IDLE);
  assign accept    = valid_in && ready_in;
  // Tail steps start only on a free slot; after the third the FSM heads home
  assign tail_step = (state == TAIL) && !phase && (tcnt != 2'd3);
  assign do_step   = accept || tail_step;
  assign blk_k     = (blklen == 13'd0) ? 13'd1 : blklen;

  // One trellis step; during termination u cancels the feedback so f = 0
  always_comb begin
    step_u = (state == TAIL) ? (s[1] ^ s[0]) : in;
    step_f = step_u ^ s[1] ^ s[0];
    step_p = step_f ^ s[2] ^ s[0];
  end

  // Next-state logic for the block sequencer
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (blk_k == 13'd1) ? TAIL : DATA;
      DATA: if (accept && ((count + 13'd1) == k_len)) state_nx = TAIL;
      TAIL: if (!phase && (tcnt == 2'd3)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, encoder memory and registered output words
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 1'b0;
      s         <= 3'b000;
      k_len     <= 13'd1;
      count     <= 13'd0;
      tcnt      <= 2'd0;
      p_q       <= 1'b0;
      out       <= 16'd0;
      valid_out <= 1'b0;
      tail_out  <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      state     <= state_nx;
      valid_out <= 1'b0;
      tail_out  <= 1'b0;
      last_out  <= 1'b0;

      if (do_step) begin
        s         <= {step_f, s[2], s[1]};
        p_q       <= step_p;
        phase     <= 1'b1;
        out       <= map_bit(step_u);
        valid_out <= 1'b1;
        tail_out  <= tail_step;
        if (tail_step) tcnt <= tcnt + 2'd1;
      end else if (phase) begin
        phase     <= 1'b0;
        out       <= map_bit(p_q);
        valid_out <= 1'b1;
        // The K-th data bit's parity is also sent in TAIL, but before any tail step
        tail_out  <= (state == TAIL) && (tcnt != 2'd0);
        last_out  <= (state == TAIL) && (tcnt == 2'd3);
      end else if (state == IDLE) begin
        s <= 3'b000;
      end

      if (accept) begin
        if (state == IDLE) begin
          k_len <= blk_k;
          count <= 13'd1;
        end else begin
          count <= count + 13'd1;
        end
      end

      if ((state == TAIL) && (state_nx == IDLE)) tcnt <= 2'd0;
    end
  end

endmodule

// File: tb/tb_rsc_encoder.sv
// tb/tb_rsc_encoder.sv - directed self-checking bench for rsc_encoder
module tb_rsc_encoder;

  logic        clk;
  logic        rst;
  logic        din;
  logic        valid_in;
  logic        ready_in;
  logic [12:0] blklen;
  logic [15:0] dout;
  logic        valid_out;
  logic        tail_out;
  logic        last_out;
  logic        busy;

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          acc_cyc = 0;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  logic [63:0] rb1, rb2;
  logic [21:0] w_imp;
  logic [7:0]  w_k1;

  rsc_encoder #(.AMPL(64)) dut (
    .clk(clk), .rst(rst), .in(din), .valid_in(valid_in), .ready_in(ready_in),
    .blklen(blklen), .out(dout), .valid_out(valid_out), .tail_out(tail_out),
    .last_out(last_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every emitted word as {out, tail, last}
  always @(negedge clk) begin
    if (!rst && valid_out) got_q.push_back({dout, tail_out, last_out});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] mw(input logic b);
`ifdef SOFT_OUT_EN
    return b ? 16'hFFC0 : 16'h0040;
`else
    return {15'b0, b};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected stream from a hand-written MSB-first word bit string
  task automatic exp_from_bits(input int k, input logic [63:0] w);
    int n;
    n = 2 * k + 6;
    for (int i = 0; i < n; i++)
      exp_q.push_back({mw(w[n - 1 - i]), (i >= 2 * k), (i == n - 1)});
  endtask

  // Reference encoder built from the recurrence f = u^s2^s3, p = f^s1^s3
  task automatic build_model(input int k, input logic [63:0] bits);
    logic [2:0] s;
    logic u, f, p;
    s = 3'b000;
    for (int i = 0; i < k + 3; i++) begin
      u = (i < k) ? bits[i] : (s[1] ^ s[0]);
      f = u ^ s[1] ^ s[0];
      p = f ^ s[2] ^ s[0];
      exp_q.push_back({mw(u), (i >= k), 1'b0});
      exp_q.push_back({mw(p), (i >= k), (i == k + 2)});
      s = {f, s[2], s[1]};
    end
  endtask

  task automatic send_bits(input int nsend, input logic [63:0] bits, input logic [12:0] bl, input int gap);
    int waited;
    blklen = bl;
    for (int i = 0; i < nsend; i++) begin
      din = bits[i];
      valid_in = 1'b1;
      waited = 0;
      while (!ready_in && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 20) chk("ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      blklen = 13'd3;
      if (gap > 0) begin
        valid_in = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_last(input string tag);
    bit seen;
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (valid_out && last_out) seen = 1;
    end
    chk({tag, "_last_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, {14'd0, got_q[i]}, {14'd0, exp_q[i]});
  endtask

  task automatic settle_and_clear;
    @(posedge clk);
    #1;
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; valid_in = 1'b0; blklen = 13'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out", {16'd0, dout}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_tail", {31'd0, tail_out}, 32'd0);
    chk("rst_last", {31'd0, last_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, ready_in}, 32'd1);
    settle_and_clear();

    // All-zero block, K=4, valid_in held high
    blklen = 13'd4; din = 1'b0; valid_in = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("z_ready_low", {31'd0, ready_in}, 32'd0);
    chk("z_busy_high", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("z_ready_high", {31'd0, ready_in}, 32'd1);
    send_bits(3, 64'd0, 13'd4, 0);
    wait_last("zero");
    chk("z_last_latency", cyc - acc_cyc, 32'd7);
    chk("z_ready_at_last", {31'd0, ready_in}, 32'd0);
    chk("z_busy_at_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("z_ready_after", {31'd0, ready_in}, 32'd1);
    chk("z_busy_after", {31'd0, busy}, 32'd0);
    exp_from_bits(4, 64'd0);
    cmp_stream("zero");
    settle_and_clear();

    // Impulse, K=8: hand-derived 22-word stream
    w_imp = 22'b1101010100000100011011;
    send_bits(8, 64'h1, 13'd8, 0);
    wait_last("imp");
    exp_from_bits(8, {42'd0, w_imp});
    settle_and_clear_keep();
    cmp_stream("impulse");
    settle_and_clear();

    // blklen=0 behaves as K=1
    w_k1 = 8'b11011011;
    send_bits(1, 64'h1, 13'd0, 0);
    wait_last("k1");
    exp_from_bits(1, {56'd0, w_k1});
    settle_and_clear_keep();
    cmp_stream("k1");
    settle_and_clear();

    // Gapped source, two back-to-back random 40-bit blocks
    rb1 = {$urandom, $urandom};
    rb2 = {$urandom, $urandom};
    send_bits(40, rb1, 13'd40, 2);
    wait_last("gap1");
    send_bits(40, rb2, 13'd40, 2);
    wait_last("gap2");
    build_model(40, rb1);
    build_model(40, rb2);
    settle_and_clear_keep();
    cmp_stream("gapped");
    settle_and_clear();

    // Reset in the middle of a block
    send_bits(5, rb1, 13'd40, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_valid", {31'd0, valid_out}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_ready", {31'd0, ready_in}, 32'd1);
    chk("mr_out", {16'd0, dout}, 32'd0);
    got_q.delete();
    repeat (12) @(negedge clk);
    chk("mr_no_tail", got_q.size(), 32'd0);
    settle_and_clear();
    send_bits(40, rb2, 13'd40, 0);
    wait_last("mr");
    build_model(40, rb2);
    settle_and_clear_keep();
    cmp_stream("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Lets the monitor record the final word before the stream is compared
  task automatic settle_and_clear_keep;
    @(posedge clk);
    #1;
  endtask

endmodule
